pps_gen_multi: RTL and testbench
================================

// Module: pps_gen_multi
// PURPOSE
//  Multi-channel successor of the single 1 Hz strobe counter. Generates CHANNELS independent
//  periodic pulses off clk, each with run-time pulse width, signed period trim (one-shot or
//  persistent) and enable. Common re-phase to the external in_hz edge via an arm/sync handshake.
//  Sits between the CPU byte bus and the timing outputs of the board.
// PARAMETERS
//  CHANNELS    4            number of pulse channels (1..8)
//  CNT_W       32           counter / trim width, bits
//  PERIOD      4_999_999    nominal terminal count (period = PERIOD+1 clk cycles)
//  WIDTH_DEF   8            reset value of every channel's pulse width, cycles
//  SYNC_OFS    3            counter preload on re-sync; compensates in_hz synchroniser latency
// PORTS
//  clk         in   1           system clock
//  clrn        in   1           reset, synchronous, active-low
//  in_hz       in   1           external 1 Hz reference, asynchronous
//  arm         in   1           1-cycle strobe: arm re-sync on next in_hz rise
//  wr_en       in   1           byte write strobe
//  wr_addr     in   6           {ch[2:0], reg[2:0]}
//  wr_data     in   8           write byte
//  sload       in   CHANNELS    per-channel strobe: staged trim -> active trim
//  pulse_out   out  CHANNELS    registered pulse outputs
//  armed       out  1           re-sync pending
//  sync_done   out  1           1-cycle strobe when re-sync applied
// BEHAVIOUR
//  Reset (clrn=0 at posedge clk): cnt=0, pulse_out=0, armed=0, sync_done=0, staged/active trim=0,
//   width=WIDTH_DEF, enable=1, persist=0, synchroniser flops=0.
//  Reg map per channel: 0..3 staged trim bytes (LSB first), 4..5 width[15:0], 6 ctrl
//   (bit0 enable, bit1 persist); 7 and ch>=CHANNELS ignored. Writes take effect next cycle.
//  in_hz: 2-FF synchroniser + edge detect; rise pulse asserted 3 clk after async edge.
//  Counter per enabled channel, each clk: limit = PERIOD + trim (signed, CNT_W+1 bits);
//   if limit < width then limit = width (always >=1 low cycle). cnt>=limit -> cnt=0 (wrap),
//   else cnt+1. On wrap, trim cleared to 0 unless persist=1.
//  pulse_out[ch] <= enable & (cnt < width), evaluated on pre-update cnt; width=0 -> never high.
//  Disabled channel: cnt held 0, pulse_out 0; re-enable starts at cnt=0 (pulse next cycle).
//  Arm handshake: arm=1 -> armed=1 (re-arm while armed is no-op). armed & rise ->
//   all channels cnt=SYNC_OFS, active trim=0, pulse_out=0 that cycle, armed=0, sync_done=1.
//  Rise without armed: ignored. arm and rise same cycle: re-sync not taken (armed set only).
//  Priority per channel, same cycle: re-sync > sload > wrap-clear of trim. sload on wrap
//   keeps new trim, used for the following period. Write to staged byte + sload same cycle:
//   sload copies the OLD staged value.
//  Trim arithmetic: signed two's complement; negative limit clamps to width.
// STRUCTURE
//  Shared include pps_gen_defs.vh: reg offsets (REG_TRIM0..3, REG_WID0..1, REG_CTRL),
//   ctrl bit indices, address field widths.
//  Sub-module pps_channel (counter, limit/clamp, trim staging, pulse register), instanced
//   CHANNELS times via generate; top holds synchroniser, arm FSM, address decode.
//  Arm FSM: IDLE (armed=0) -arm-> ARMED -rise-> SYNC (1 cycle, sync_done=1) -> IDLE.
// TESTING (PERIOD=99, WIDTH_DEF=8, SYNC_OFS=3, CHANNELS=4)
//  Release reset, idle -> each pulse_out high 8 cycles, period 100 cycles, all in phase.
//  ch1 trim=+10 persist=0, sload -> one 110-cycle period, then back to 100; other channels unaffected.
//  ch2 trim=-95 persist=1 -> limit 4 clamped to width 8: period 9, high 8, low 1, repeats.
//  arm, in_hz rise 40 cycles later -> sync_done 3 cycles after edge; all cnt=3; next pulses aligned.
//  in_hz rise without arm, and arm+rise same cycle -> no re-phase, sync_done stays 0.
//  ch3 ctrl enable=0 mid-pulse -> pulse_out[3]=0 next cycle; re-enable -> high next cycle, 100-cycle period.

Source files
------------

// File: rtl/pps_gen_multi_pkg.sv
// Register map, control bit positions and arm FSM states shared by the pps_gen_multi slice.
// Pure declarations; no logic, no latency, no flow control.
package pps_gen_multi_pkg;

    localparam int CH_W  = 3;
    localparam int REG_W = 3;
    localparam int WID_W = 16;

    localparam logic [REG_W-1:0] REG_TRIM0 = 3'd0;
    localparam logic [REG_W-1:0] REG_TRIM1 = 3'd1;
    localparam logic [REG_W-1:0] REG_TRIM2 = 3'd2;
    localparam logic [REG_W-1:0] REG_TRIM3 = 3'd3;
    localparam logic [REG_W-1:0] REG_WID0  = 3'd4;
    localparam logic [REG_W-1:0] REG_WID1  = 3'd5;
    localparam logic [REG_W-1:0] REG_CTRL  = 3'd6;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_PERSIST = 1;

    typedef enum logic [1:0] {
        ARM_IDLE,
        ARM_ARMED,
        ARM_SYNC
    } arm_state_t;

endpackage

// File: rtl/pps_channel.sv
// One pulse channel: trimmed/clamped period counter, staged trim, byte registers, pulse flop.
// pulse is registered from the pre-update count (1 clk); no backpressure, always accepts writes.
module pps_channel
    import pps_gen_multi_pkg::*;
#(
    parameter int CNT_W     = 32,
    parameter int PERIOD    = 4_999_999,
    parameter int WIDTH_DEF = 8,
    parameter int SYNC_OFS  = 3
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             wr_en,
    input  logic [REG_W-1:0] wr_reg,
    input  logic [7:0]       wr_data,
    input  logic             sload,
    input  logic             resync,
    output logic             pulse
);

    localparam logic signed [CNT_W:0] PERIOD_S = (CNT_W+1)'(PERIOD);

    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        trim_stg;
    logic [CNT_W-1:0]        trim_act;
    logic [WID_W-1:0]        width;
    logic                    enable;
    logic                    persist;
    logic signed [CNT_W:0]   limit_raw;
    logic signed [CNT_W:0]   width_s;
    logic [CNT_W:0]          limit;
    logic                    wrap;

    // The clamp to width guarantees at least one low cycle per period, even for large negative trim.
    always_comb begin
        width_s   = $signed({{(CNT_W+1-WID_W){1'b0}}, width});
        limit_raw = PERIOD_S + $signed({trim_act[CNT_W-1], trim_act});
        limit     = (limit_raw < width_s) ? width_s : limit_raw;
        wrap      = ({1'b0, cnt} >= limit);
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            cnt      <= '0;
            trim_stg <= '0;
            trim_act <= '0;
            width    <= WID_W'(WIDTH_DEF);
            enable   <= 1'b1;
            persist  <= 1'b0;
            pulse    <= 1'b0;
        end else begin
            if (!enable) begin
                cnt   <= '0;
                pulse <= 1'b0;
            end else if (resync) begin
                cnt   <= CNT_W'(SYNC_OFS);
                pulse <= 1'b0;
            end else begin
                pulse <= ({1'b0, cnt} < $unsigned(width_s));
                cnt   <= wrap ? '0 : cnt + CNT_W'(1);
            end

            // sload reads the staged value before this cycle's byte write lands.
            if (resync)
                trim_act <= '0;
            else if (sload)
                trim_act <= trim_stg;
            else if (enable && wrap && !persist)
                trim_act <= '0;

            // Trim bytes assume CNT_W == 32.
            if (wr_en) begin
                case (wr_reg)
                    REG_TRIM0: trim_stg[7:0]   <= wr_data;
                    REG_TRIM1: trim_stg[15:8]  <= wr_data;
                    REG_TRIM2: trim_stg[23:16] <= wr_data;
                    REG_TRIM3: trim_stg[31:24] <= wr_data;
                    REG_WID0:  width[7:0]      <= wr_data;
                    REG_WID1:  width[15:8]     <= wr_data;
                    REG_CTRL: begin
                        enable  <= wr_data[CTRL_EN];
                        persist <= wr_data[CTRL_PERSIST];
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/pps_gen_multi.sv
// Multi-channel periodic pulse generator with byte register bus and in_hz re-phase handshake.
// Pulses registered (1 clk); re-sync lands 3 clk after the in_hz edge; no backpressure.
module pps_gen_multi
    import pps_gen_multi_pkg::*;
#(
    parameter int CHANNELS  = 4,
    parameter int CNT_W     = 32,
    parameter int PERIOD    = 4_999_999,
    parameter int WIDTH_DEF = 8,
    parameter int SYNC_OFS  = 3
) (
    input  logic                clk,
    input  logic                clrn,
    input  logic                in_hz,
    input  logic                arm,
    input  logic                wr_en,
    input  logic [5:0]          wr_addr,
    input  logic [7:0]          wr_data,
    input  logic [CHANNELS-1:0] sload,
    output logic [CHANNELS-1:0] pulse_out,
    output logic                armed,
    output logic                sync_done
);

    logic [2:0] hz_sync;
    logic       hz_rise;
    logic       resync;
    arm_state_t state;
    arm_state_t state_nxt;

    always_ff @(posedge clk) begin
        if (!clrn) begin
            hz_sync <= '0;
            state   <= ARM_IDLE;
        end else begin
            hz_sync <= {hz_sync[1:0], in_hz};
            state   <= state_nxt;
        end
    end

    // hz_sync[2] is only the edge-detect history, not a third synchroniser stage.
    assign hz_rise = hz_sync[1] & ~hz_sync[2];

    always_comb begin
        state_nxt = state;
        resync    = 1'b0;
        armed     = 1'b0;
        sync_done = 1'b0;
        case (state)
            ARM_IDLE: begin
                if (arm)
                    state_nxt = ARM_ARMED;
            end
            ARM_ARMED: begin
                armed = 1'b1;
                if (hz_rise) begin
                    resync    = 1'b1;
                    state_nxt = ARM_SYNC;
                end
            end
            ARM_SYNC: begin
                sync_done = 1'b1;
                state_nxt = ARM_IDLE;
            end
            default: state_nxt = ARM_IDLE;
        endcase
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic ch_wr;
        assign ch_wr = wr_en && (wr_addr[REG_W +: CH_W] == CH_W'(g));

        pps_channel #(
            .CNT_W     (CNT_W),
            .PERIOD    (PERIOD),
            .WIDTH_DEF (WIDTH_DEF),
            .SYNC_OFS  (SYNC_OFS)
        ) u_ch (
            .clk     (clk),
            .clrn    (clrn),
            .wr_en   (ch_wr),
            .wr_reg  (wr_addr[REG_W-1:0]),
            .wr_data (wr_data),
            .sload   (sload[g]),
            .resync  (resync),
            .pulse   (pulse_out[g])
        );
    end

endmodule

// File: tb/tb_pps_gen_multi.sv
// Bench for pps_gen_multi: per-cycle expected outputs queued from a behavioural model, plus
// directed period / phase / latency checks derived from the pulse edge history.
module tb_pps_gen_multi;

    localparam int NCH  = 4;
    localparam int PER  = 99;
    localparam int WDEF = 8;
    localparam int SOFS = 3;

    logic           clk = 1'b0;
    logic           clrn;
    logic           in_hz;
    logic           arm;
    logic           wr_en;
    logic [5:0]     wr_addr;
    logic [7:0]     wr_data;
    logic [NCH-1:0] sload;
    logic [NCH-1:0] pulse_out;
    logic           armed;
    logic           sync_done;

    always #5 clk = ~clk;

    pps_gen_multi #(
        .CHANNELS  (NCH),
        .CNT_W     (32),
        .PERIOD    (PER),
        .WIDTH_DEF (WDEF),
        .SYNC_OFS  (SOFS)
    ) dut (
        .clk       (clk),
        .clrn      (clrn),
        .in_hz     (in_hz),
        .arm       (arm),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .sload     (sload),
        .pulse_out (pulse_out),
        .armed     (armed),
        .sync_done (sync_done)
    );

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int sync_seen = 0;
    int e_cyc, sync_cyc, m_cyc, k;
    logic [5:0] exp_q[$];
    logic [5:0] last_obs = '0;
    int rises[NCH][$];
    int falls[NCH][$];
    int hi_cnt[NCH];

    // behavioural reference state
    int          m_cnt[NCH];
    logic [31:0] m_stg[NCH];
    logic [31:0] m_act[NCH];
    logic [15:0] m_wid[NCH];
    bit          m_en[NCH];
    bit          m_per[NCH];
    bit          m_pls[NCH];
    bit          h0, h1, h2;
    int          st;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic model_step(output logic [5:0] e);
        bit     rise, go, wrap;
        int     nst;
        longint lim;
        if (!clrn) begin
            for (int ch = 0; ch < NCH; ch++) begin
                m_cnt[ch] = 0; m_stg[ch] = '0; m_act[ch] = '0; m_wid[ch] = 16'(WDEF);
                m_en[ch] = 1'b1; m_per[ch] = 1'b0; m_pls[ch] = 1'b0;
            end
            h0 = 0; h1 = 0; h2 = 0; st = 0;
        end else begin
            rise = h1 && !h2;
            go   = (st == 1) && rise;
            case (st)
                0:       nst = arm ? 1 : 0;
                1:       nst = rise ? 2 : 1;
                default: nst = 0;
            endcase
            for (int ch = 0; ch < NCH; ch++) begin
                wrap = 1'b0;
                if (!m_en[ch]) begin
                    m_pls[ch] = 1'b0;
                    m_cnt[ch] = 0;
                end else if (go) begin
                    m_pls[ch] = 1'b0;
                    m_cnt[ch] = SOFS;
                end else begin
                    m_pls[ch] = (m_cnt[ch] < int'(m_wid[ch]));
                    lim = longint'(PER) + longint'($signed(m_act[ch]));
                    if (lim < longint'(m_wid[ch])) lim = longint'(m_wid[ch]);
                    if (longint'(m_cnt[ch]) >= lim) begin
                        m_cnt[ch] = 0;
                        wrap = 1'b1;
                    end else begin
                        m_cnt[ch]++;
                    end
                end
                if (go) m_act[ch] = '0;
                else if (sload[ch]) m_act[ch] = m_stg[ch];
                else if (wrap && !m_per[ch]) m_act[ch] = '0;
                if (wr_en && int'(wr_addr[5:3]) == ch) begin
                    case (wr_addr[2:0])
                        3'd0: m_stg[ch][7:0]   = wr_data;
                        3'd1: m_stg[ch][15:8]  = wr_data;
                        3'd2: m_stg[ch][23:16] = wr_data;
                        3'd3: m_stg[ch][31:24] = wr_data;
                        3'd4: m_wid[ch][7:0]   = wr_data;
                        3'd5: m_wid[ch][15:8]  = wr_data;
                        3'd6: begin m_en[ch] = wr_data[0]; m_per[ch] = wr_data[1]; end
                        default: ;
                    endcase
                end
            end
            h2 = h1; h1 = h0; h0 = in_hz;
            st = nst;
        end
        e = {m_pls[3], m_pls[2], m_pls[1], m_pls[0], st == 1, st == 2};
    endtask

    // One clock: predict, advance, then compare the DUT #1 after the edge.
    task automatic cycle();
        logic [5:0] e, obs;
        model_step(e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        obs = {pulse_out, armed, sync_done};
        check($sformatf("cyc%0d", cyc), 32'(obs), 32'(exp_q.pop_front()));
        for (int ch = 0; ch < NCH; ch++) begin
            if (obs[ch+2] && !last_obs[ch+2]) rises[ch].push_back(cyc);
            if (!obs[ch+2] && last_obs[ch+2]) falls[ch].push_back(cyc);
            if (obs[ch+2]) hi_cnt[ch]++;
        end
        if (obs[0]) sync_seen++;
        last_obs = obs;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic wr(input logic [2:0] ch, input logic [2:0] r, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = {ch, r}; wr_data = d;
        cycle();
        wr_en = 1'b0;
    endtask

    task automatic clear_hist();
        for (int ch = 0; ch < NCH; ch++) begin
            rises[ch].delete();
            falls[ch].delete();
            hi_cnt[ch] = 0;
        end
    endtask

    function automatic int count_iv(input int ch, input int val);
        int n = 0;
        for (int i = 1; i < rises[ch].size(); i++)
            if (rises[ch][i] - rises[ch][i-1] == val) n++;
        return n;
    endfunction

    task automatic wait_rise(input int ch, input string tag);
        int n = 0;
        while (rises[ch].size() == 0 && n < 300) begin
            cycle();
            n++;
        end
        check(tag, 32'(rises[ch].size() > 0), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        clrn = 1'b0; in_hz = 1'b0; arm = 1'b0; wr_en = 1'b0;
        wr_addr = '0; wr_data = '0; sload = '0;
        #1;
        idle(3);
        clrn = 1'b1;
        clear_hist();
        idle(250);

        // idle: 8-cycle pulses every 100 cycles, all channels in phase
        check("idle_nrise", rises[0].size(), 3);
        check("idle_period0", rises[0][1] - rises[0][0], 100);
        check("idle_period1", rises[0][2] - rises[0][1], 100);
        check("idle_high", falls[0][0] - rises[0][0], WDEF);
        for (int ch = 1; ch < NCH; ch++)
            check($sformatf("idle_phase%0d", ch), rises[ch][0], rises[0][0]);

        // ch1 +10 one-shot trim; the final sload shares its cycle with a new staged byte
        clear_hist();
        wait_rise(1, "ch1_wait");
        wr(3'd1, 3'd0, 8'd10); wr(3'd1, 3'd1, 8'd0); wr(3'd1, 3'd2, 8'd0); wr(3'd1, 3'd3, 8'd0);
        wr(3'd1, 3'd6, 8'h01);
        wr_en = 1'b1; wr_addr = {3'd1, 3'd0}; wr_data = 8'd20; sload = 4'b0010;
        cycle();
        wr_en = 1'b0; sload = '0;
        idle(340);
        check("ch1_nrise", 32'(rises[1].size() >= 3), 32'd1);
        check("ch1_p110", count_iv(1, 110), 1);
        check("ch1_p100", count_iv(1, 100), rises[1].size() - 2);
        check("ch0_p100", count_iv(0, 100), rises[0].size() - 1);

        // ch2 -95 persistent: clamped to width -> period 9, 8 high
        wr(3'd2, 3'd0, 8'hA1); wr(3'd2, 3'd1, 8'hFF); wr(3'd2, 3'd2, 8'hFF); wr(3'd2, 3'd3, 8'hFF);
        wr(3'd2, 3'd6, 8'h03);
        sload = 4'b0100;
        cycle();
        sload = '0;
        idle(30);
        clear_hist();
        idle(45);
        check("ch2_nrise", 32'(rises[2].size() >= 4), 32'd1);
        check("ch2_p9", count_iv(2, 9), rises[2].size() - 1);
        check("ch2_high", hi_cnt[2], 40);

        // arm, then in_hz rise 40 cycles later
        arm = 1'b1;
        cycle();
        arm = 1'b0;
        check("armed_set", 32'(last_obs[1]), 32'd1);
        idle(39);
        in_hz = 1'b1;
        e_cyc = cyc + 1;
        k = 0;
        do begin
            cycle();
            k++;
        end while (!last_obs[0] && k < 10);
        sync_cyc = cyc;
        check("sync_seen", 32'(last_obs[0]), 32'd1);
        check("sync_latency", sync_cyc - e_cyc + 1, 3);
        check("armed_clr", 32'(last_obs[1]), 32'd0);
        clear_hist();
        idle(150);
        for (int ch = 0; ch < NCH; ch++) begin
            check($sformatf("resync_first%0d", ch), rises[ch][0], sync_cyc + 1);
            check($sformatf("resync_next%0d", ch), rises[ch][1], sync_cyc + 98);
        end

        // rise without arm, then arm coincident with the synchronised rise
        sync_seen = 0;
        in_hz = 1'b0; idle(5);
        in_hz = 1'b1; idle(10);
        in_hz = 1'b0; idle(5);
        in_hz = 1'b1; idle(2);
        arm = 1'b1;
        cycle();
        arm = 1'b0;
        idle(10);
        check("no_rephase", sync_seen, 0);
        check("arm_pending", 32'(last_obs[1]), 32'd1);

        // ch3 disable mid-pulse, then re-enable
        k = 0;
        while (!last_obs[5] && k < 200) begin
            cycle();
            k++;
        end
        check("ch3_wait", 32'(last_obs[5]), 32'd1);
        wr(3'd3, 3'd6, 8'h00);
        cycle();
        check("ch3_off", 32'(last_obs[5]), 32'd0);
        idle(20);
        clear_hist();
        wr(3'd3, 3'd6, 8'h01);
        m_cyc = cyc;
        cycle();
        check("ch3_on", 32'(last_obs[5]), 32'd1);
        idle(220);
        check("ch3_first", rises[3][0], m_cyc + 1);
        check("ch3_period", rises[3][1] - rises[3][0], 100);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
